// File: rtl/motor_pkg.sv
// Shared motor-control definitions: direction command codes, H-bridge FSM
// state encoding and the default dead-time length.
package motor_pkg;

    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_FWD   = 2'b01;
    localparam logic [1:0] DIR_REV   = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    typedef enum logic [2:0] {
        ST_COAST = 3'd0,
        ST_FWD   = 3'd1,
        ST_REV   = 3'd2,
        ST_BRAKE = 3'd3,
        ST_DEAD  = 3'd4,
        ST_FAULT = 3'd5
    } drv_state_e;

    // 50 cycles = 1 us at 50 MHz
    localparam int DEAD_CYCLES_DEF = 50;

    function automatic drv_state_e dir_to_state(input logic [1:0] dir);
        case (dir)
            DIR_FWD:   return ST_FWD;
            DIR_REV:   return ST_REV;
            DIR_BRAKE: return ST_BRAKE;
            default:   return ST_COAST;
        endcase
    endfunction

endpackage

// File: rtl/hbridge_dir_ctrl_if.sv
// Direction-command handshake between the motor controller and one H-bridge channel.
interface hbridge_dir_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_dir, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_dir, output cmd_ready);
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with synchronous active-high reset; also used
// for the wheel encoder inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q, sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/hbridge_dir_ctrl.sv
// One H-bridge channel: direction FSM with dead-time on reversals and a
// synchronised PWM path. Optional PWM-loss watchdog: HBRIDGE_PWM_WDOG_EN.
module hbridge_dir_ctrl
    import motor_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
    parameter int WD_CYCLES   = 100_000_000
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic              pwm_in,
    hbridge_dir_ctrl_if.slave cmd,
    output logic              in1,
    output logic              in2,
    output logic [2:0]        drv_state,
    output logic              fault
);
    localparam int CNT_W = $clog2(DEAD_CYCLES + 1);

    drv_state_e       state_q, state_d, tgt_q, tgt_d, req;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in1_q, in1_d, in2_q, in2_d, rdy_q, rdy_d;
    logic             pwm_s, acc;

    sync_2ff #(.WIDTH(1)) u_pwm_sync (
        .clk (clk_50MHz),
        .rst (reset),
        .d   (pwm_in),
        .q   (pwm_s)
    );

`ifdef HBRIDGE_PWM_WDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            pwm_prev_q, pwm_rise, fault_q;
    assign pwm_rise = pwm_s & ~pwm_prev_q;
`endif

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        req     = dir_to_state(cmd.cmd_dir);
        acc     = cmd.cmd_valid & rdy_q;
        case (state_q)
            ST_COAST, ST_FWD, ST_REV, ST_BRAKE: begin
                if (acc && req != state_q) begin
                    // Leaving or entering coast never shoots through; everything else waits out dead-time
                    if (state_q == ST_COAST || req == ST_COAST) begin
                        state_d = req;
                    end else begin
                        state_d = ST_DEAD;
                        tgt_d   = req;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DEAD: begin
                if (cnt_q == CNT_W'(DEAD_CYCLES - 1)) state_d = tgt_q;
                else                                  cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_FAULT: begin
                if (acc && req == ST_COAST) state_d = ST_COAST;
            end
            default: state_d = ST_COAST;
        endcase
`ifdef HBRIDGE_PWM_WDOG_EN
        wd_d = '0;
        if (state_q == ST_FWD || state_q == ST_REV) begin
            wd_d = pwm_rise ? '0 : wd_q + WD_W'(1);
            if (!pwm_rise && wd_d == WD_W'(WD_CYCLES)) state_d = ST_FAULT;
        end
`endif
        in1_d = (state_d == ST_FWD && pwm_s) || state_d == ST_BRAKE;
        in2_d = (state_d == ST_REV && pwm_s) || state_d == ST_BRAKE;
        rdy_d = state_d != ST_DEAD;
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state_q <= ST_COAST;
            tgt_q   <= ST_COAST;
            cnt_q   <= '0;
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            rdy_q   <= rdy_d;
        end
    end

`ifdef HBRIDGE_PWM_WDOG_EN
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            wd_q       <= '0;
            pwm_prev_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            wd_q       <= wd_d;
            pwm_prev_q <= pwm_s;
            fault_q    <= state_d == ST_FAULT;
        end
    end
    assign fault = fault_q;
`else
    wire wd_cfg_unused = (WD_CYCLES > 0);
    assign fault = 1'b0;
`endif

    assign cmd.cmd_ready = rdy_q;
    assign in1           = in1_q;
    assign in2           = in2_q;
    assign drv_state     = state_q;
endmodule
